// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution tile sequencer.
// The window packing helper maps (row, col) of a 4x4 tile to its flat element index.
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    MAC  = 3'd2,
    OUT  = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam int DEF_LEN_IN  = 8;
  localparam int DEF_LEN_OUT = 25;

  function automatic int win_idx(input int r, input int c);
    return r * 4 + c;
  endfunction

endpackage

// File: rtl/conv_row_loader.sv
// Walks the 5-cycle LOAD phase: issues row reads for one channel's 4x4 window and
// kernel, and captures each returned row into the tile registers one cycle later.
module conv_row_loader
  import conv_pkg::*;
#(
  parameter int LEN_IN = DEF_LEN_IN,
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 16,
  parameter int STRIDE = 1,
  parameter int FM_AW  = 10,
  parameter int KR_AW  = 4,
  parameter int CH_W   = 2,
  parameter int ROW_W  = 4,
  parameter int COL_W  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 active_i,
  input  logic [CH_W-1:0]      ch_i,
  input  logic [ROW_W-1:0]     row_i,
  input  logic [COL_W-1:0]     col_i,
  input  logic [4*LEN_IN-1:0]  fm_rd_data_i,
  input  logic [4*LEN_IN-1:0]  kr_rd_data_i,
  output logic                 last_o,
  output logic                 fm_rd_en_o,
  output logic [FM_AW-1:0]     fm_addr_o,
  output logic                 kr_rd_en_o,
  output logic [KR_AW-1:0]     kr_addr_o,
  output logic [16*LEN_IN-1:0] win_o,
  output logic [16*LEN_IN-1:0] ker_o
);

  logic [2:0]       k_q, k_d;
  logic [FM_AW-1:0] fm_addr_q, fm_addr_d;
  logic [KR_AW-1:0] kr_addr_q, kr_addr_d;
  logic             issue, capture;
  logic [1:0]       cap_row;

  assign issue   = active_i && !k_q[2];
  assign capture = active_i && (k_q != 3'd0);
  assign cap_row = 2'(k_q - 3'd1);
  assign last_o  = active_i && (k_q == 3'd4);

  always_comb begin
    k_d = '0;
    if (active_i && k_q != 3'd4) k_d = k_q + 3'd1;
  end

  // Output positions are in window steps; scale by STRIDE to reach pixel coordinates.
  assign fm_addr_d = FM_AW'((32'(ch_i) * 32'(IMG_H) + 32'(row_i) * 32'(STRIDE) + 32'(k_q))
                            * 32'(IMG_W) + 32'(col_i) * 32'(STRIDE));
  assign kr_addr_d = KR_AW'(32'(ch_i) * 32'd4 + 32'(k_q));

  assign fm_rd_en_o = issue;
  assign kr_rd_en_o = issue;
  assign fm_addr_o  = issue ? fm_addr_d : fm_addr_q;
  assign kr_addr_o  = issue ? kr_addr_d : kr_addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q       <= '0;
      fm_addr_q <= '0;
      kr_addr_q <= '0;
    end else begin
      k_q <= k_d;
      if (issue) begin
        fm_addr_q <= fm_addr_d;
        kr_addr_q <= kr_addr_d;
      end
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_row
    localparam int BASE = win_idx(gi, 0) * LEN_IN;
    logic [4*LEN_IN-1:0] win_row_q, ker_row_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        win_row_q <= '0;
        ker_row_q <= '0;
      end else if (capture && cap_row == 2'(gi)) begin
        win_row_q <= fm_rd_data_i;
        ker_row_q <= kr_rd_data_i;
      end
    end

    assign win_o[BASE +: 4*LEN_IN] = win_row_q;
    assign ker_o[BASE +: 4*LEN_IN] = ker_row_q;
  end

endmodule

// File: rtl/conv_tile_sequencer.sv
// Drives an external 4x4 MAC over every output position of a multi-channel feature map,
// accumulating channels through mac_last and streaming one result per position.
module conv_tile_sequencer
  import conv_pkg::*;
#(
  parameter int LEN_IN  = DEF_LEN_IN,
  parameter int LEN_OUT = DEF_LEN_OUT,
  parameter int IMG_W   = 16,
  parameter int IMG_H   = 16,
  parameter int NUM_CH  = 4,
  parameter int STRIDE  = 1,
  localparam int FM_AW  = $clog2(NUM_CH * IMG_H * IMG_W),
  localparam int KR_AW  = $clog2(NUM_CH * 4),
  localparam int ROW_W  = $clog2(IMG_H),
  localparam int COL_W  = $clog2(IMG_W)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 fm_rd_en,
  output logic [FM_AW-1:0]     fm_addr,
  input  logic [4*LEN_IN-1:0]  fm_rd_data,
  output logic                 kr_rd_en,
  output logic [KR_AW-1:0]     kr_addr,
  input  logic [4*LEN_IN-1:0]  kr_rd_data,
  output logic [16*LEN_IN-1:0] mac_data,
  output logic [16*LEN_IN-1:0] mac_kernel,
  output logic [LEN_OUT-1:0]   mac_last,
  input  logic [LEN_OUT-1:0]   mac_result,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LEN_OUT-1:0]   out_data,
  output logic [ROW_W-1:0]     out_row,
  output logic [COL_W-1:0]     out_col
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int OUT_W = (IMG_W - 4) / STRIDE + 1;
  localparam int OUT_H = (IMG_H - 4) / STRIDE + 1;

  state_t              state_q, state_d;
  logic [CH_W-1:0]     ch_q;
  logic [ROW_W-1:0]    row_q;
  logic [COL_W-1:0]    col_q;
  logic [LEN_OUT-1:0]  acc_q;
  logic                load_active, load_last, last_ch, last_pos;

  assign last_ch  = (ch_q == CH_W'(NUM_CH - 1));
  assign last_pos = (row_q == ROW_W'(OUT_H - 1)) && (col_q == COL_W'(OUT_W - 1));

  always_comb begin
    state_d     = state_q;
    busy        = 1'b0;
    done        = 1'b0;
    out_valid   = 1'b0;
    load_active = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = LOAD;
      LOAD: begin
        busy        = 1'b1;
        load_active = 1'b1;
        if (load_last) state_d = MAC;
      end
      MAC: begin
        busy    = 1'b1;
        state_d = last_ch ? OUT : LOAD;
      end
      OUT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = last_pos ? DONE : LOAD;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ch_q    <= '0;
      row_q   <= '0;
      col_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (start) begin
          ch_q  <= '0;
          row_q <= '0;
          col_q <= '0;
        end
        MAC: begin
          acc_q <= mac_result;
          if (!last_ch) ch_q <= ch_q + 1'b1;
        end
        OUT: if (out_ready) begin
          ch_q <= '0;
          if (!last_pos) begin
            if (col_q == COL_W'(OUT_W - 1)) begin
              col_q <= '0;
              row_q <= row_q + 1'b1;
            end else begin
              col_q <= col_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Channel 0 must start from zero, not from the previous position's sum.
  assign mac_last = (ch_q == '0) ? '0 : acc_q;
  assign out_data = acc_q;
  assign out_row  = row_q;
  assign out_col  = col_q;

  conv_row_loader #(
    .LEN_IN (LEN_IN),
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .STRIDE (STRIDE),
    .FM_AW  (FM_AW),
    .KR_AW  (KR_AW),
    .CH_W   (CH_W),
    .ROW_W  (ROW_W),
    .COL_W  (COL_W)
  ) u_loader (
    .clk          (clk),
    .rst_n        (rst_n),
    .active_i     (load_active),
    .ch_i         (ch_q),
    .row_i        (row_q),
    .col_i        (col_q),
    .fm_rd_data_i (fm_rd_data),
    .kr_rd_data_i (kr_rd_data),
    .last_o       (load_last),
    .fm_rd_en_o   (fm_rd_en),
    .fm_addr_o    (fm_addr),
    .kr_rd_en_o   (kr_rd_en),
    .kr_addr_o    (kr_addr),
    .win_o        (mac_data),
    .ker_o        (mac_kernel)
  );

endmodule

// File: tb/tb_conv_tile_sequencer.sv
// Scoreboard bench: a direct-convolution reference fills the expected queue per pass,
// and a negedge monitor checks every handshake, stall and done pulse.
module tb_conv_tile_sequencer;

  localparam int LI = 8, LO = 25, IW = 16, IH = 16, NC = 4, ST = 1;
  localparam int OW = (IW - 4) / ST + 1, OH = (IH - 4) / ST + 1;
  localparam int NPOS = OW * OH;
  localparam int PASS_CYC = NPOS * (6 * NC + 1);
  localparam int SLO = 16;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0, fails = 0;
  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- main DUT (defaults) ----------------
  logic             start = 1'b0, busy, done, fm_rd_en, kr_rd_en, out_valid;
  logic             out_ready = 1'b1;
  logic [9:0]       fm_addr;
  logic [3:0]       kr_addr, out_row, out_col;
  logic [4*LI-1:0]  fm_rd_data = '0, kr_rd_data = '0;
  logic [16*LI-1:0] mac_data, mac_kernel;
  logic [LO-1:0]    mac_last, mac_result, out_data;

  conv_tile_sequencer u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .fm_rd_en(fm_rd_en), .fm_addr(fm_addr), .fm_rd_data(fm_rd_data),
    .kr_rd_en(kr_rd_en), .kr_addr(kr_addr), .kr_rd_data(kr_rd_data),
    .mac_data(mac_data), .mac_kernel(mac_kernel), .mac_last(mac_last), .mac_result(mac_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_col(out_col)
  );

  logic [LI-1:0] pix [NC*IH*IW];
  logic [LI-1:0] kw  [NC*16];

  always @(posedge clk) begin
    if (fm_rd_en)
      fm_rd_data <= {pix[int'(fm_addr)+3], pix[int'(fm_addr)+2], pix[int'(fm_addr)+1], pix[int'(fm_addr)]};
    if (kr_rd_en)
      kr_rd_data <= {kw[int'(kr_addr)*4+3], kw[int'(kr_addr)*4+2], kw[int'(kr_addr)*4+1], kw[int'(kr_addr)*4]};
  end

  always_comb begin : mac_model
    longint s;
    s = longint'($signed(mac_last));
    for (int i = 0; i < 16; i++)
      s += longint'($signed(mac_data[i*LI +: LI])) * longint'($signed(mac_kernel[i*LI +: LI]));
    mac_result = LO'(s);
  end

  // ---------------- small DUT: 4x4 image, one channel, 16-bit result ----------------
  logic             s_start = 1'b0, s_busy, s_done, s_fm_rd_en, s_kr_rd_en, s_out_valid;
  logic             s_out_ready = 1'b1;
  logic [3:0]       s_fm_addr;
  logic [1:0]       s_kr_addr, s_out_row, s_out_col;
  logic [4*LI-1:0]  s_fm_rd_data = '0, s_kr_rd_data = '0;
  logic [16*LI-1:0] s_mac_data, s_mac_kernel;
  logic [SLO-1:0]   s_mac_last, s_mac_result, s_out_data;

  conv_tile_sequencer #(.LEN_OUT(SLO), .IMG_W(4), .IMG_H(4), .NUM_CH(1)) u_sml (
    .clk(clk), .rst_n(rst_n), .start(s_start), .busy(s_busy), .done(s_done),
    .fm_rd_en(s_fm_rd_en), .fm_addr(s_fm_addr), .fm_rd_data(s_fm_rd_data),
    .kr_rd_en(s_kr_rd_en), .kr_addr(s_kr_addr), .kr_rd_data(s_kr_rd_data),
    .mac_data(s_mac_data), .mac_kernel(s_mac_kernel), .mac_last(s_mac_last), .mac_result(s_mac_result),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .out_row(s_out_row), .out_col(s_out_col)
  );

  logic [LI-1:0] s_pix [16];
  logic [LI-1:0] s_kw  [16];

  always @(posedge clk) begin
    if (s_fm_rd_en)
      s_fm_rd_data <= {s_pix[int'(s_fm_addr)+3], s_pix[int'(s_fm_addr)+2], s_pix[int'(s_fm_addr)+1], s_pix[int'(s_fm_addr)]};
    if (s_kr_rd_en)
      s_kr_rd_data <= {s_kw[int'(s_kr_addr)*4+3], s_kw[int'(s_kr_addr)*4+2], s_kw[int'(s_kr_addr)*4+1], s_kw[int'(s_kr_addr)*4]};
  end

  always_comb begin : s_mac_model
    longint s;
    s = longint'($signed(s_mac_last));
    for (int i = 0; i < 16; i++)
      s += longint'($signed(s_mac_data[i*LI +: LI])) * longint'($signed(s_mac_kernel[i*LI +: LI]));
    s_mac_result = SLO'(s);
  end

  // ---------------- reference model and scoreboard ----------------
  typedef struct { longint data; int row; int col; } exp_t;
  exp_t sb[$];

  function automatic longint ref_sum(input int r, input int c);
    longint t = 0;
    logic [LO-1:0] w;
    for (int ch = 0; ch < NC; ch++)
      for (int kr = 0; kr < 4; kr++)
        for (int kc = 0; kc < 4; kc++)
          t += longint'($signed(pix[(ch*IH + r*ST + kr)*IW + c*ST + kc])) *
               longint'($signed(kw[ch*16 + kr*4 + kc]));
    w = LO'(t);
    return longint'($signed(w));
  endfunction

  task automatic fill_and_push(input int fill);
    exp_t e;
    for (int i = 0; i < NC*IH*IW; i++) pix[i] = (fill == 0) ? 8'd1 : 8'($urandom);
    for (int i = 0; i < NC*16; i++)    kw[i]  = (fill == 0) ? 8'd1 : 8'($urandom);
    sb.delete();
    for (int r = 0; r < OH; r++)
      for (int c = 0; c < OW; c++) begin
        e.data = ref_sum(r, c); e.row = r; e.col = c;
        sb.push_back(e);
      end
  endtask

  // ---------------- monitor ----------------
  int n_res = 0, n_done = 0, start_cyc = 0, done_rel = -1;
  bit seen_valid = 0, stall_prev = 0;
  logic [LO-1:0] prev_data;
  logic [3:0]    prev_row, prev_col;

  always @(negedge clk) begin
    int rel;
    exp_t e;
    if (rst_n) begin
      rel = cyc - start_cyc;
      if (stall_prev) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, prev_data);
        chk("stall_row", out_row, prev_row);
        chk("stall_col", out_col, prev_col);
        chk("stall_fm_rd", fm_rd_en, 0);
        chk("stall_kr_rd", kr_rd_en, 0);
      end
      if (out_valid && !seen_valid) begin
        seen_valid = 1;
        chk("first_valid_cycle", rel + 1, 6*NC + 1);
      end
      if (out_valid && out_ready) begin
        chk("sb_nonempty", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("out_data", longint'($signed(out_data)), e.data);
          chk("out_row", out_row, e.row);
          chk("out_col", out_col, e.col);
          chk("rd_in_out", fm_rd_en, 0);
        end
        n_res++;
      end
      stall_prev = out_valid && !out_ready;
      prev_data = out_data; prev_row = out_row; prev_col = out_col;
      if (done) begin
        n_done++;
        done_rel = rel;
        chk("done_without_valid", out_valid, 0);
        chk("done_not_busy", busy, 0);
      end
    end
  end

  // ---------------- out_ready driver ----------------
  int ready_mode = 0, stall_left = 0;
  initial forever begin
    @(posedge clk); #1;
    case (ready_mode)
      1: out_ready = ($urandom_range(0, 9) < 7);
      2: if (out_valid && n_res == 4 && stall_left > 0) begin
           out_ready = 1'b0;
           stall_left--;
         end else out_ready = 1'b1;
      default: out_ready = 1'b1;
    endcase
  end

  task automatic begin_pass(input int fill, input int rmode);
    fill_and_push(fill);
    ready_mode = rmode; stall_left = 10;
    n_res = 0; seen_valid = 0; done_rel = -1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic run_pass(input int fill, input int rmode, input bit glitch, input bit timed);
    int d0;
    d0 = n_done;
    begin_pass(fill, rmode);
    for (int i = 0; i < PASS_CYC * 4 && n_done == d0; i++) begin
      @(posedge clk); #1;
      start = glitch && busy && ($urandom_range(0, 49) == 0);
    end
    start = 1'b0;
    repeat (4) @(posedge clk);
    chk("pass_done_pulses", n_done - d0, 1);
    chk("pass_results", n_res, NPOS);
    chk("pass_sb_empty", sb.size(), 0);
    if (timed) chk("pass_done_cycle", done_rel + 1, PASS_CYC + 1);
  endtask

  task automatic reset_abort();
    int d0;
    bit hit;
    hit = 0;
    d0 = n_done;
    begin_pass(1, 1);
    for (int i = 0; i < PASS_CYC * 4; i++) begin
      @(negedge clk);
      if (n_res == 3*OW + 4 && kr_rd_en && kr_addr == 4'd8) begin hit = 1; break; end
    end
    chk("abort_point_reached", hit, 1);
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_valid", out_valid, 0);
    chk("abort_fm_rd", fm_rd_en, 0);
    chk("abort_kr_rd", kr_rd_en, 0);
    chk("abort_fm_addr", fm_addr, 0);
    chk("abort_kr_addr", kr_addr, 0);
    chk("abort_out_data", out_data, 0);
    chk("abort_out_pos", {out_row, out_col}, 0);
    chk("abort_mac_last", mac_last, 0);
    chk("abort_mac_data", |{mac_data, mac_kernel}, 0);
    chk("abort_no_done", n_done - d0, 0);
    sb.delete();
    stall_prev = 0;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic small_run(input logic [7:0] pv, input logic [7:0] kv, input longint exp_data);
    int vat, dat;
    vat = -1; dat = -1;
    for (int i = 0; i < 16; i++) begin s_pix[i] = pv; s_kw[i] = kv; end
    @(posedge clk); #1 s_start = 1'b1;
    @(posedge clk); #1 s_start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (s_out_valid && vat < 0) begin
        vat = i;
        chk("small_data", longint'($signed(s_out_data)), exp_data);
        chk("small_pos", {s_out_row, s_out_col}, 0);
      end
      if (s_done && dat < 0) dat = i;
    end
    chk("small_valid_cycle", vat + 1, 7);
    chk("small_done_cycle", dat + 1, 8);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_fm_rd", fm_rd_en, 0);
    chk("rst_fm_addr", fm_addr, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_mac_last", mac_last, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    small_run(8'd1, 8'd2, 32);
    small_run(8'd127, 8'd127, -4080);

    run_pass(0, 0, 1'b0, 1'b1);   // all ones, free-flowing: every result 64
    run_pass(0, 2, 1'b0, 1'b0);   // 10-cycle stall on result 5
    run_pass(1, 1, 1'b0, 1'b0);   // random data, random backpressure
    reset_abort();
    run_pass(1, 0, 1'b0, 1'b1);   // clean restart after abort
    run_pass(1, 0, 1'b1, 1'b1);   // start pulsed while busy

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
